// File: rtl/bp_pkg.sv
// Shared constants and types for the branch resolve controller and its in-flight queue.
package bp_pkg;

  localparam int unsigned IDX_W      = 5;
  localparam int unsigned TABLE_SIZE = 2 ** IDX_W;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } bp_state_e;

  typedef struct packed {
    logic             taken;
    logic [31:0]      target;
    logic [31:0]      fallthrough;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] ghr;
  } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predicted branches awaiting resolution; flush wins over push and pop.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  bp_entry_t              push_data,
  output bp_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bp_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks in-flight predicted branches, drives predictor updates and mispredict redirects,
// sweeps the predictor tables after reset and keeps saturating branch statistics.
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic                     pred_taken,
  input  logic [31:0]              pred_target,
  input  logic [31:0]              pred_fallthrough,
  input  logic [IDX_W-1:0]         pred_index,
  input  logic [IDX_W-1:0]         pred_ghr,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_index,
  output logic                     upd_taken,
  output logic [31:0]              upd_target,
  output logic                     init_we,
  output logic [IDX_W-1:0]         init_index,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic [IDX_W-1:0]         ghr_restore,
  output logic                     busy,
  output logic [$clog2(Q_DEPTH):0] q_count,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt,
  output logic                     err_underflow
);

  localparam int unsigned QC_W = $clog2(Q_DEPTH) + 1;

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  bp_entry_t        head, push_entry;
  logic             do_push, do_pop, mispredict;
  logic [QC_W-1:0]  count_d;
  logic [31:0]      actual_pc;

  logic             pred_ready_d, upd_valid_d, upd_taken_d, init_we_d, redirect_valid_d;
  logic             busy_d, err_underflow_d;
  logic [IDX_W-1:0] upd_index_d, init_index_d, ghr_restore_d;
  logic [31:0]      upd_target_d, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_d, mispred_cnt_d;

  assign push_entry = '{taken:       pred_taken,
                        target:      pred_target,
                        fallthrough: pred_fallthrough,
                        index:       pred_index,
                        ghr:         pred_ghr};

  // pred_ready already implies RUN and a non-full queue for the current cycle.
  assign do_push    = pred_valid && pred_ready && (state_q == RUN);
  assign do_pop     = res_valid && (state_q != INIT) && (q_count != '0);
  assign mispredict = do_pop && ((res_taken != head.taken) ||
                                 (res_taken && (res_target != head.target)));
  assign actual_pc  = res_taken ? res_target : head.fallthrough;
  assign count_d    = mispredict ? '0 : q_count + QC_W'(do_push) - QC_W'(do_pop);

  bp_inflight_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .push      (do_push),
    .pop       (do_pop),
    .flush     (mispredict),
    .push_data (push_entry),
    .head      (head),
    .count     (q_count)
  );

  always_comb begin
    state_d          = state_q;
    sweep_d          = sweep_q;
    init_we_d        = 1'b0;
    busy_d           = 1'b0;
    init_index_d     = init_index;
    upd_valid_d      = 1'b0;
    upd_index_d      = upd_index;
    upd_taken_d      = upd_taken;
    upd_target_d     = upd_target;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc;
    ghr_restore_d    = ghr_restore;
    branch_cnt_d     = branch_cnt;
    mispred_cnt_d    = mispred_cnt;
    err_underflow_d  = err_underflow;

    case (state_q)
      INIT: begin
        init_we_d    = 1'b1;
        busy_d       = 1'b1;
        init_index_d = sweep_q;
        sweep_d      = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(TABLE_SIZE - 1)) state_d = RUN;
      end
      RUN:     if (mispredict) state_d = FLUSH;
      FLUSH:   state_d = mispredict ? FLUSH : RUN;
      default: state_d = INIT;
    endcase

    if (do_pop) begin
      upd_valid_d  = 1'b1;
      upd_index_d  = head.index;
      upd_taken_d  = res_taken;
      upd_target_d = actual_pc;
      if (branch_cnt != '1) branch_cnt_d = branch_cnt + CNT_W'(1);
    end

    if (mispredict) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = actual_pc;
      ghr_restore_d    = {head.ghr[IDX_W-2:0], res_taken};
      if (mispred_cnt != '1) mispred_cnt_d = mispred_cnt + CNT_W'(1);
    end

    if (res_valid && (state_q != INIT) && (q_count == '0)) err_underflow_d = 1'b1;

    // Ready opens one cycle after the sweep ends and after the single flush cycle.
    pred_ready_d = (state_d == RUN) && (state_q != INIT) && (count_d < QC_W'(Q_DEPTH));
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= INIT;
      sweep_q        <= '0;
      pred_ready     <= 1'b0;
      upd_valid      <= 1'b0;
      upd_index      <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
      init_we        <= 1'b0;
      init_index     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ghr_restore    <= '0;
      busy           <= 1'b0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
      err_underflow  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sweep_q        <= sweep_d;
      pred_ready     <= pred_ready_d;
      upd_valid      <= upd_valid_d;
      upd_index      <= upd_index_d;
      upd_taken      <= upd_taken_d;
      upd_target     <= upd_target_d;
      init_we        <= init_we_d;
      init_index     <= init_index_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      ghr_restore    <= ghr_restore_d;
      busy           <= busy_d;
      branch_cnt     <= branch_cnt_d;
      mispred_cnt    <= mispred_cnt_d;
      err_underflow  <= err_underflow_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_branch_resolve_ctrl;

  localparam int unsigned IW = 5;
  localparam int unsigned QD = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          pred_valid, pred_ready, pred_taken;
  logic [31:0]   pred_target, pred_fallthrough;
  logic [IW-1:0] pred_index, pred_ghr;
  logic          res_valid, res_taken;
  logic [31:0]   res_target;
  logic          upd_valid, upd_taken, init_we, redirect_valid, busy, err_underflow;
  logic [IW-1:0] upd_index, init_index, ghr_restore;
  logic [31:0]   upd_target, redirect_pc;
  logic [2:0]    q_count;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.Q_DEPTH(QD), .CNT_W(CW)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_fallthrough(pred_fallthrough),
    .pred_index(pred_index), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
    .init_we(init_we), .init_index(init_index),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ghr_restore(ghr_restore),
    .busy(busy), .q_count(q_count), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
    .err_underflow(err_underflow)
  );

  typedef struct {
    bit          taken;
    bit [31:0]   target;
    bit [31:0]   fall;
    bit [IW-1:0] idx;
    bit [IW-1:0] ghr;
  } ent_t;

  ent_t mq[$];
  ent_t cur_push;
  bit   m_run, m_flush, m_under;
  int   m_br, m_mis;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(bit t, bit [31:0] tgt, bit [31:0] fall, bit [IW-1:0] idx, bit [IW-1:0] ghr);
    ent_t e;
    e.taken = t; e.target = tgt; e.fall = fall; e.idx = idx; e.ghr = ghr;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(1'($urandom), $urandom, $urandom, IW'($urandom), IW'($urandom));
  endfunction

  task automatic set_push(input bit v, input ent_t e);
    cur_push         = e;
    pred_valid       = v;
    pred_taken       = e.taken;
    pred_target      = e.target;
    pred_fallthrough = e.fall;
    pred_index       = e.idx;
    pred_ghr         = e.ghr;
  endtask

  task automatic set_res(input bit v, input bit t, input bit [31:0] tgt);
    res_valid  = v;
    res_taken  = t;
    res_target = tgt;
  endtask

  // Resolve the oldest model entry with the outcome it predicted.
  task automatic res_match();
    if (mq.size() > 0) set_res(1'b1, mq[0].taken, mq[0].taken ? mq[0].target : $urandom);
    else               set_res(1'b1, 1'b0, 32'h0);
  endtask

  task automatic idle();
    set_push(1'b0, mk(0, 0, 0, 0, 0));
    set_res(1'b0, 1'b0, 32'h0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_flush = 0; m_under = 0; m_br = 0; m_mis = 0;
  endtask

  // One RUN-mode clock: predict from the model, advance the clock, compare.
  task automatic cycle();
    bit        ready, acc, pop, mis;
    ent_t      h;
    bit [31:0] pc;
    ready = m_run && !m_flush && (mq.size() < QD);
    chk("pred_ready", pred_ready, ready);
    acc = pred_valid && ready;
    pop = 0; mis = 0; pc = 0;
    if (res_valid && m_run) begin
      if (mq.size() == 0) m_under = 1;
      else begin
        h   = mq.pop_front();
        pop = 1;
        mis = (res_taken != h.taken) || (res_taken && res_target != h.target);
        pc  = res_taken ? res_target : h.fall;
        if (m_br < 65535) m_br++;
        if (mis && m_mis < 65535) m_mis++;
      end
    end
    if (mis) mq.delete();
    else if (acc) mq.push_back(cur_push);
    @(posedge clk); #1;
    m_flush = mis;
    chk("upd_valid", upd_valid, pop);
    if (pop) begin
      chk("upd_index", upd_index, h.idx);
      chk("upd_taken", upd_taken, res_taken);
      chk("upd_target", upd_target, pc);
    end
    chk("redirect_valid", redirect_valid, mis);
    if (mis) begin
      chk("redirect_pc", redirect_pc, pc);
      chk("ghr_restore", ghr_restore, {h.ghr[IW-2:0], res_taken});
    end
    chk("q_count", q_count, mq.size());
    chk("branch_cnt", branch_cnt, m_br);
    chk("mispred_cnt", mispred_cnt, m_mis);
    chk("err_underflow", err_underflow, m_under);
    chk("busy_run", busy, 0);
    chk("init_we_run", init_we, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pred_ready"}, pred_ready, 0);
    chk({tag, "_upd_valid"}, upd_valid, 0);
    chk({tag, "_upd_target"}, upd_target, 0);
    chk({tag, "_init_we"}, init_we, 0);
    chk({tag, "_init_index"}, init_index, 0);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_q_count"}, q_count, 0);
    chk({tag, "_branch_cnt"}, branch_cnt, 0);
    chk({tag, "_mispred_cnt"}, mispred_cnt, 0);
    chk({tag, "_err_underflow"}, err_underflow, 0);
  endtask

  // Reset was just released before a rising edge: expect the full table sweep.
  task automatic sweep_check();
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      chk("sweep_init_we", init_we, 1);
      chk("sweep_init_index", init_index, k);
      chk("sweep_busy", busy, 1);
      chk("sweep_pred_ready", pred_ready, 0);
    end
    @(posedge clk); #1;
    chk("post_sweep_init_we", init_we, 0);
    chk("post_sweep_busy", busy, 0);
    chk("post_sweep_pred_ready", pred_ready, 1);
    m_run = 1;
  endtask

  initial begin
    idle();
    model_reset();
    Reset_n = 1'b0;
    #3;
    chk_all_zero("reset");
    #19 Reset_n = 1'b1;
    sweep_check();

    // Correct taken prediction
    set_push(1'b1, mk(1, 32'h100, 32'h1004, 5'd3, 5'b00101)); cycle();
    idle(); set_res(1'b1, 1'b1, 32'h100); cycle();
    chk("cp_upd_index", upd_index, 3);
    chk("cp_upd_target", upd_target, 32'h100);
    chk("cp_redirect", redirect_valid, 0);
    chk("cp_branch_cnt", branch_cnt, 1);
    idle(); cycle();

    // Direction mispredict with two younger entries behind it
    set_push(1'b1, mk(0, 32'h300, 32'h44, 5'd7, 5'b01010)); cycle();
    set_push(1'b1, rnd_ent()); cycle();
    set_push(1'b1, rnd_ent()); cycle();
    idle(); set_res(1'b1, 1'b1, 32'h80); set_push(1'b1, rnd_ent()); cycle();
    chk("dm_redirect_pc", redirect_pc, 32'h80);
    chk("dm_ghr_restore", ghr_restore, 5'b10101);
    chk("dm_q_count", q_count, 0);
    chk("dm_mispred_cnt", mispred_cnt, 1);
    idle();
    chk("dm_flush_ready", pred_ready, 0);
    cycle();
    chk("dm_ready_back", pred_ready, 1);

    // Target mispredict
    set_push(1'b1, mk(1, 32'h200, 32'h1238, 5'd9, 5'b11001)); cycle();
    idle(); set_res(1'b1, 1'b1, 32'h240); cycle();
    chk("tm_redirect_pc", redirect_pc, 32'h240);
    chk("tm_upd_target", upd_target, 32'h240);
    idle(); cycle();

    // Fill, refuse push while full, concurrent push/pop at count 3, drain, underflow
    for (int i = 0; i < 4; i++) begin set_push(1'b1, rnd_ent()); cycle(); end
    idle();
    chk("full_ready", pred_ready, 0);
    set_push(1'b1, rnd_ent()); res_match(); cycle();
    chk("full_refuse_count", q_count, 3);
    set_push(1'b1, rnd_ent()); res_match(); cycle();
    chk("concurrent_count", q_count, 3);
    for (int i = 0; i < 3; i++) begin idle(); res_match(); cycle(); end
    idle(); set_res(1'b1, 1'b1, 32'h0); cycle();
    chk("underflow_flag", err_underflow, 1);
    chk("underflow_no_upd", upd_valid, 0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_push(1'($urandom), rnd_ent());
      if (mq.size() > 0 && ($urandom % 2) == 1) begin
        if (($urandom % 4) != 0) res_match();
        else set_res(1'b1, 1'($urandom), $urandom);
      end else begin
        set_res(1'b0, 1'b0, 32'h0);
      end
      cycle();
    end

    // Drain, queue two entries, then reset mid-run
    idle(); cycle();
    for (int i = 0; i < QD + 2; i++) begin
      idle();
      if (mq.size() > 0) res_match();
      cycle();
    end
    set_push(1'b1, rnd_ent()); cycle();
    set_push(1'b1, rnd_ent()); cycle();
    chk("pre_reset_count", q_count, 2);
    idle();
    #2 Reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(negedge clk);
    #2 Reset_n = 1'b1;
    sweep_check();
    set_push(1'b1, rnd_ent()); cycle();
    idle(); res_match(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequencing controller wrapped around the gshare predictor.
- Holds a small in-order queue of in-flight predicted branches (index, GHR snapshot, predicted direction/target) between IF and EX.
- On EX resolution, compares the outcome against the oldest entry, drives the predictor's single update port, and issues flush/redirect plus GHR restore on mispredict.
- Owns the post-reset table-clear sweep and saturating branch/mispredict statistics.

Parameters:
- IDX_W, 5, width of GHPT/BTB index and GHR
- TABLE_SIZE, 32, entries swept during init (2**IDX_W)
- Q_DEPTH, 4, in-flight queue entries (power of 2, >=2)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- Reset_n  in  1  async active-low reset
- pred_valid  in  1  IF pushes a predicted branch
- pred_ready  out  1  queue accepts push
- pred_taken  in  1  predicted direction
- pred_target  in  32  predicted taken target
- pred_fallthrough  in  32  PC+4 of the branch
- pred_index  in  IDX_W  GHPT/BTB index used for prediction
- pred_ghr  in  IDX_W  GHR at prediction time
- res_valid  in  1  EX resolves oldest branch
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- upd_valid  out  1  predictor update strobe
- upd_index  out  IDX_W  table index to update
- upd_taken  out  1  outcome for 2-bit counter
- upd_target  out  32  BTB write data
- init_we  out  1  table-clear write strobe
- init_index  out  IDX_W  table-clear address
- redirect_valid  out  1  mispredict flush/redirect pulse
- redirect_pc  out  32  correct next PC
- ghr_restore  out  IDX_W  repaired GHR, valid with redirect_valid
- busy  out  1  high in INIT
- q_count  out  $clog2(Q_DEPTH)+1  occupancy
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispred_cnt  out  CNT_W  mispredicts, saturating
- err_underflow  out  1  sticky: res_valid with empty queue

Behaviour:
- Reset (async, Reset_n=0): every output 0 and queue empty. State enters INIT with init_index=0. Reset mid-operation discards in-flight entries and restarts the sweep.
- INIT:
  - init_we=1 and busy=1; init_index increments each cycle from 0 to TABLE_SIZE-1 (TABLE_SIZE cycles).
  - Moves to RUN after the last index.
  - pred_ready=0; res_valid is ignored.
- RUN:
  - pred_ready = (q_count<Q_DEPTH). A push is accepted on pred_valid&&pred_ready.
  - A full queue refuses the push even if a pop occurs the same cycle.
- Resolution: res_valid with a non-empty queue pops the oldest entry. mispredict = (res_taken!=pred_taken) || (res_taken && res_target!=pred_target).
- Outputs registered, 1-cycle latency after res_valid:
  - upd_valid=1 for one cycle with upd_index=entry.index, upd_taken=res_taken, upd_target = res_taken ? res_target : entry.fallthrough.
  - branch_cnt+1 (saturating).
- Mispredict, same registered cycle:
  - redirect_valid=1, redirect_pc = res_taken ? res_target : entry.fallthrough, ghr_restore = {entry.ghr[IDX_W-2:0],res_taken}.
  - mispred_cnt+1 (saturating).
  - The whole queue is flushed (count=0) at the resolve edge, and any push in that same cycle is dropped.
  - State goes to FLUSH for 1 cycle (pred_ready=0), then RUN.
- Correct prediction: no redirect. A simultaneous push and pop keeps the count unchanged.
- Empty queue with res_valid: no update, no counter change, err_underflow set (cleared only by reset).
- Counters hold at all-ones. Queue pointers wrap modulo Q_DEPTH.

Decomposition:
- Shared package bp_pkg holds:
  - IDX_W and TABLE_SIZE constants
  - state enum {INIT, RUN, FLUSH}
  - typedef bp_entry_t {taken, target[31:0], fallthrough[31:0], index, ghr}
- One sub-module: bp_inflight_fifo. Parameterised synchronous FIFO of bp_entry_t with push/pop/flush and count; flush has priority over push.

Test Plan:
- Reset release: INIT sweep → init_we high for 32 cycles, init_index 0..31, busy then 0, pred_ready=1 on cycle 33.
- Correct prediction: push taken, target 0x100, index 3, ghr 5'b00101; resolve taken 0x100 → next cycle upd_valid, upd_index=3, upd_target=0x100, redirect_valid=0, branch_cnt=1.
- Direction mispredict: push not-taken, fallthrough 0x44, ghr 5'b01010, plus two younger pushes; resolve taken 0x80 → redirect_pc=0x80, ghr_restore=5'b10101, q_count=0, pred_ready=0 one cycle, mispred_cnt=1.
- Target mispredict: predicted taken 0x200, actual taken 0x240 → redirect_pc=0x240, upd_target=0x240.
- Full/concurrency: fill 4 entries → pred_ready=0; push and correct resolve in the same cycle at count 3 → count stays 3; resolve on empty queue → err_underflow=1, no upd_valid.
- Reset mid-run with 2 entries queued → all outputs 0 immediately, q_count=0, INIT sweep restarts at index 0.
